// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer: FSM states and the
// per-cycle pipeline register control word with its canonical values.
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      ERROR    = 2'd2
   } pctrl_state_t;

   typedef struct packed {
      logic pc_en;
      logic if_id_en;
      logic if_id_flush;
      logic id_ex_en;
      logic id_ex_flush;
      logic ex_mem_en;
   } pipe_ctl_t;

   // Everything frozen, nothing cleared.
   localparam pipe_ctl_t NOP_CTL = '{pc_en: 1'b0, if_id_en: 1'b0, if_id_flush: 1'b0,
                                     id_ex_en: 1'b0, id_ex_flush: 1'b0, ex_mem_en: 1'b0};
   localparam pipe_ctl_t RUN_CTL = '{pc_en: 1'b1, if_id_en: 1'b1, if_id_flush: 1'b0,
                                     id_ex_en: 1'b1, id_ex_flush: 1'b0, ex_mem_en: 1'b1};
   // Hold PC and IF/ID, push a bubble into EX while the load moves on.
   localparam pipe_ctl_t LOAD_USE_CTL = '{pc_en: 1'b0, if_id_en: 1'b0, if_id_flush: 1'b0,
                                          id_ex_en: 1'b1, id_ex_flush: 1'b1, ex_mem_en: 1'b1};
   // Redirect PC and squash the two younger instructions in IF/ID and ID/EX.
   localparam pipe_ctl_t BRANCH_CTL = '{pc_en: 1'b1, if_id_en: 1'b1, if_id_flush: 1'b1,
                                        id_ex_en: 1'b1, id_ex_flush: 1'b1, ex_mem_en: 1'b1};

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard comparator between the ID instruction's
// source registers and the destination of a load sitting in EX.
module load_use_detect (
   input  logic [4:0] id_rs1_addr_i,
   input  logic [4:0] id_rs2_addr_i,
   input  logic       id_uses_rs1_i,
   input  logic       id_uses_rs2_i,
   input  logic       ex_mem_read_i,
   input  logic [4:0] ex_rd_addr_i,
   output logic       load_use_o
);

   logic rs1_hit;
   logic rs2_hit;

   assign rs1_hit = id_uses_rs1_i && (id_rs1_addr_i == ex_rd_addr_i);
   assign rs2_hit = id_uses_rs2_i && (id_rs2_addr_i == ex_rd_addr_i);

   // x0 is hardwired to zero, so a load targeting it never creates a dependency.
   assign load_use_o = ex_mem_read_i && (ex_rd_addr_i != 5'd0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline: resolves load-use,
// taken-branch and data-memory wait hazards, with a wait watchdog and counters.
module pipeline_hazard_ctrl #(
   parameter int unsigned MEM_TIMEOUT = 255,
   parameter int unsigned CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       id_rs1_addr,
   input  logic [4:0]       id_rs2_addr,
   input  logic             id_uses_rs1,
   input  logic             id_uses_rs2,
   input  logic             ex_mem_read,
   input  logic [4:0]       ex_rd_addr,
   input  logic             ex_branch_taken,
   input  logic             mem_req,
   input  logic             mem_ready,
   output logic             pc_en,
   output logic             if_id_en,
   output logic             if_id_flush,
   output logic             id_ex_en,
   output logic             id_ex_flush,
   output logic             ex_mem_en,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   import pipe_ctrl_pkg::*;

   localparam int unsigned     WAIT_W   = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

   pctrl_state_t      state_q, state_d;
   logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
   logic              mem_timeout_q, mem_timeout_d;

   logic      load_use;
   logic      mem_stall;
   logic      branch_accept;
   pipe_ctl_t ctl;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   load_use_detect u_load_use_detect (
      .id_rs1_addr_i (id_rs1_addr),
      .id_rs2_addr_i (id_rs2_addr),
      .id_uses_rs1_i (id_uses_rs1),
      .id_uses_rs2_i (id_uses_rs2),
      .ex_mem_read_i (ex_mem_read),
      .ex_rd_addr_i  (ex_rd_addr),
      .load_use_o    (load_use)
   );

   assign mem_stall = mem_req && !mem_ready;

   always_comb begin
      state_d       = state_q;
      wait_cnt_d    = wait_cnt_q;
      mem_timeout_d = mem_timeout_q;
      ctl           = NOP_CTL;
      branch_accept = 1'b0;
      if (!rst) begin
         case (state_q)
            ERROR: begin
               ctl = NOP_CTL;
            end
            default: begin
               if (mem_stall) begin
                  // Branch and load-use decisions wait: the frozen registers keep presenting them.
                  ctl = NOP_CTL;
                  if (state_q == RUN) begin
                     state_d    = MEM_WAIT;
                     wait_cnt_d = WAIT_W'(1);
                  end else if (wait_cnt_q == WAIT_MAX) begin
                     state_d       = ERROR;
                     mem_timeout_d = 1'b1;
                  end else begin
                     wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                  end
               end else begin
                  state_d    = RUN;
                  wait_cnt_d = '0;
                  if (ex_branch_taken) begin
                     ctl           = BRANCH_CTL;
                     branch_accept = 1'b1;
                  end else if (load_use) begin
                     ctl = LOAD_USE_CTL;
                  end else begin
                     ctl = RUN_CTL;
                  end
               end
            end
         endcase
      end
   end

   always_comb begin
      stall_cnt_d = ctl.pc_en   ? stall_cnt_q : sat_inc(stall_cnt_q);
      flush_cnt_d = branch_accept ? sat_inc(flush_cnt_q) : flush_cnt_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= RUN;
         wait_cnt_q    <= '0;
         stall_cnt_q   <= '0;
         flush_cnt_q   <= '0;
         mem_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         wait_cnt_q    <= wait_cnt_d;
         stall_cnt_q   <= stall_cnt_d;
         flush_cnt_q   <= flush_cnt_d;
         mem_timeout_q <= mem_timeout_d;
      end
   end

   assign pc_en       = ctl.pc_en;
   assign if_id_en    = ctl.if_id_en;
   assign if_id_flush = ctl.if_id_flush;
   assign id_ex_en    = ctl.id_ex_en;
   assign id_ex_flush = ctl.id_ex_flush;
   assign ex_mem_en   = ctl.ex_mem_en;
   assign mem_timeout = mem_timeout_q;
   assign stall_cnt   = stall_cnt_q;
   assign flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: a default instance and a small one
// (MEM_TIMEOUT=4, CNT_W=4) share stimulus and are checked against a rule model.
module tb_pipeline_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] id_rs1_addr, id_rs2_addr, ex_rd_addr;
   logic       id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken, mem_req, mem_ready;

   logic        pc_en_a, if_id_en_a, if_id_flush_a, id_ex_en_a, id_ex_flush_a, ex_mem_en_a, mem_timeout_a;
   logic [31:0] stall_cnt_a, flush_cnt_a;
   logic        pc_en_b, if_id_en_b, if_id_flush_b, id_ex_en_b, id_ex_flush_b, ex_mem_en_b, mem_timeout_b;
   logic [3:0]  stall_cnt_b, flush_cnt_b;

   int total = 0;
   int bad   = 0;

   // Model state per instance: sticky error, consecutive stalled cycles, counters.
   bit          m_err[2];
   int unsigned m_run[2];
   logic [31:0] m_stall[2];
   logic [31:0] m_flush[2];

   always #5 clk = ~clk;

   pipeline_hazard_ctrl #(.MEM_TIMEOUT(255), .CNT_W(32)) u_dut (
      .clk(clk), .rst(rst),
      .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
      .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
      .ex_mem_read(ex_mem_read), .ex_rd_addr(ex_rd_addr),
      .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
      .pc_en(pc_en_a), .if_id_en(if_id_en_a), .if_id_flush(if_id_flush_a),
      .id_ex_en(id_ex_en_a), .id_ex_flush(id_ex_flush_a), .ex_mem_en(ex_mem_en_a),
      .mem_timeout(mem_timeout_a), .stall_cnt(stall_cnt_a), .flush_cnt(flush_cnt_a)
   );

   pipeline_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) u_dut_s (
      .clk(clk), .rst(rst),
      .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
      .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
      .ex_mem_read(ex_mem_read), .ex_rd_addr(ex_rd_addr),
      .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
      .pc_en(pc_en_b), .if_id_en(if_id_en_b), .if_id_flush(if_id_flush_b),
      .id_ex_en(id_ex_en_b), .id_ex_flush(id_ex_flush_b), .ex_mem_en(ex_mem_en_b),
      .mem_timeout(mem_timeout_b), .stall_cnt(stall_cnt_b), .flush_cnt(flush_cnt_b)
   );

   function automatic int unsigned timeout_of(int k);
      return (k == 0) ? 255 : 4;
   endfunction

   function automatic logic [31:0] cnt_max(int k);
      return (k == 0) ? 32'hFFFF_FFFF : 32'd15;
   endfunction

   // Expected {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en}.
   function automatic logic [5:0] exp_ctl(int k);
      logic lu;
      lu = ex_mem_read && (ex_rd_addr != 5'd0) &&
           ((id_uses_rs1 && id_rs1_addr == ex_rd_addr) || (id_uses_rs2 && id_rs2_addr == ex_rd_addr));
      if (rst || m_err[k] || (mem_req && !mem_ready)) return 6'b000000;
      if (ex_branch_taken) return 6'b111111;
      if (lu) return 6'b000111;
      return 6'b110101;
   endfunction

   function automatic logic [5:0] obs_ctl(int k);
      if (k == 0) return {pc_en_a, if_id_en_a, if_id_flush_a, id_ex_en_a, id_ex_flush_a, ex_mem_en_a};
      return {pc_en_b, if_id_en_b, if_id_flush_b, id_ex_en_b, id_ex_flush_b, ex_mem_en_b};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Check outputs mid-cycle, then advance the model across the rising edge.
   task automatic cyc();
      logic [5:0] e[2];
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         e[k] = exp_ctl(k);
         chk($sformatf("ctl%0d", k), 32'(obs_ctl(k)), 32'(e[k]));
      end
      chk("stall_a", stall_cnt_a, m_stall[0]);
      chk("flush_a", flush_cnt_a, m_flush[0]);
      chk("tmo_a", 32'(mem_timeout_a), 32'(m_err[0]));
      chk("stall_b", 32'(stall_cnt_b), m_stall[1]);
      chk("flush_b", 32'(flush_cnt_b), m_flush[1]);
      chk("tmo_b", 32'(mem_timeout_b), 32'(m_err[1]));
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            m_err[k] = 1'b0; m_run[k] = 0; m_stall[k] = '0; m_flush[k] = '0;
         end else begin
            if (!e[k][5] && m_stall[k] != cnt_max(k)) m_stall[k] = m_stall[k] + 1;
            if (e[k] == 6'b111111 && m_flush[k] != cnt_max(k)) m_flush[k] = m_flush[k] + 1;
            if (!m_err[k]) begin
               if (mem_req && !mem_ready) begin
                  m_run[k] = m_run[k] + 1;
                  if (m_run[k] > timeout_of(k)) m_err[k] = 1'b1;
               end else begin
                  m_run[k] = 0;
               end
            end
         end
      end
      #1;
   endtask

   task automatic idle();
      rst = 1'b0; id_rs1_addr = '0; id_rs2_addr = '0; ex_rd_addr = '0;
      id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; ex_mem_read = 1'b0;
      ex_branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
   endtask

   task automatic set_load_use();
      ex_mem_read = 1'b1; ex_rd_addr = 5'd5; id_rs1_addr = 5'd5; id_uses_rs1 = 1'b1;
   endtask

   initial begin
      for (int k = 0; k < 2; k++) begin
         m_err[k] = 1'b0; m_run[k] = 0; m_stall[k] = '0; m_flush[k] = '0;
      end
      idle();
      rst = 1'b1;
      @(posedge clk);
      #1;

      // Reset overrides pending hazards.
      rst = 1'b1; ex_branch_taken = 1'b1; set_load_use();
      cyc();
      idle();
      cyc();

      // Load-use: one bubble, then normal once the load leaves EX.
      set_load_use();
      cyc();
      idle();
      cyc();
      chk("t1_stall_cnt", stall_cnt_a, 32'd1);

      // x0 destination and unused source never stall; rs2 path does.
      set_load_use(); ex_rd_addr = 5'd0; id_rs1_addr = 5'd0;
      cyc();
      set_load_use(); id_uses_rs1 = 1'b0;
      cyc();
      set_load_use(); id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b1; id_rs2_addr = 5'd5;
      cyc();
      chk("t2_stall_cnt", stall_cnt_a, 32'd2);

      // Taken branch wins over a same-cycle load-use.
      set_load_use(); ex_branch_taken = 1'b1;
      cyc();
      chk("t3_flush_cnt", flush_cnt_a, 32'd1);
      chk("t3_stall_cnt", stall_cnt_a, 32'd2);

      // Memory wait of three cycles; branch raised mid-wait acts on release.
      idle(); mem_req = 1'b1;
      cyc();
      ex_branch_taken = 1'b1;
      cyc();
      cyc();
      chk("t4_flush_held", flush_cnt_a, 32'd1);
      mem_ready = 1'b1;
      cyc();
      idle();
      cyc();
      chk("t4_flush_cnt", flush_cnt_a, 32'd2);
      chk("t4_stall_cnt", stall_cnt_a, 32'd5);

      // Watchdog on the small instance, sticky until reset.
      idle(); mem_req = 1'b1;
      for (int i = 0; i < 7; i++) cyc();
      chk("t5_tmo_b", 32'(mem_timeout_b), 32'd1);
      chk("t5_tmo_a", 32'(mem_timeout_a), 32'd0);
      idle();
      cyc();
      cyc();
      chk("t5_sticky", 32'(mem_timeout_b), 32'd1);
      rst = 1'b1;
      cyc();
      idle();
      chk("t5_rst_tmo", 32'(mem_timeout_b), 32'd0);
      chk("t5_rst_stall", 32'(stall_cnt_b), 32'd0);
      chk("t5_rst_flush", flush_cnt_a, 32'd0);

      // Reset in the middle of a wait restarts the watchdog.
      mem_req = 1'b1;
      for (int i = 0; i < 3; i++) cyc();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) cyc();
      chk("t5_midwait_tmo", 32'(mem_timeout_b), 32'd0);
      rst = 1'b1;
      cyc();
      idle();

      // Sustained load-use stalls saturate the 4-bit counter.
      set_load_use();
      for (int i = 0; i < 20; i++) cyc();
      chk("t6_sat_b", 32'(stall_cnt_b), 32'd15);
      chk("t6_cnt_a", stall_cnt_a, 32'd20);
      idle();
      cyc();

      // Randomized traffic.
      for (int i = 0; i < 2000; i++) begin
         rst             = ($urandom_range(0, 99) == 0);
         id_rs1_addr     = 5'($urandom_range(0, 3));
         id_rs2_addr     = 5'($urandom_range(0, 3));
         ex_rd_addr      = 5'($urandom_range(0, 3));
         id_uses_rs1     = 1'($urandom_range(0, 1));
         id_uses_rs2     = 1'($urandom_range(0, 1));
         ex_mem_read     = 1'($urandom_range(0, 1));
         ex_branch_taken = ($urandom_range(0, 4) == 0);
         mem_req         = ($urandom_range(0, 4) < 2);
         mem_ready       = ($urandom_range(0, 9) < 7);
         cyc();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
